aq32_bus_interconnect: RTL and testbench

//   Parametrised CPU-bus decoder/interconnect for the aq32 core: routes one CPU bus master to NUM_SLAVES slaves.
//   Per-slave base/mask decode, per-slave handshake or fixed-latency wait generation, read-data mux.
//   Bus-error response for unmapped accesses and for handshake slaves exceeding a timeout; first-error capture.

---
 rtl/aq32_bus_interconnect_if.sv | 20 ++
 rtl/aq32_bus_interconnect.sv | 176 +++++++++++++++++
 tb/tb_aq32_bus_interconnect.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/aq32_bus_interconnect_if.sv
// CPU-side bus of the aq32 interconnect: request from the core, stall/data/error back.
// "master" is the CPU view, "slave" is the interconnect view.
interface aq32_bus_interconnect_if;
  logic [31:0] cpu_addr;
  logic        cpu_wren;
  logic        cpu_strobe;
  logic        cpu_wait;
  logic [31:0] cpu_rddata;
  logic        cpu_error;

  modport master (
    output cpu_addr, cpu_wren, cpu_strobe,
    input  cpu_wait, cpu_rddata, cpu_error
  );

  modport slave (
    input  cpu_addr, cpu_wren, cpu_strobe,
    output cpu_wait, cpu_rddata, cpu_error
  );
endinterface

// File: rtl/aq32_bus_interconnect.sv
// aq32 CPU-bus decoder: base/mask decode, handshake or fixed-latency wait generation,
// read-data mux, bus errors for unmapped/timed-out accesses with first-error capture.
module aq32_bus_interconnect #(
  parameter int                     NUM_SLAVES    = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE  = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK  = {NUM_SLAVES{32'hFFFF_FFFF}},
  parameter logic [NUM_SLAVES*4-1:0]  SLAVE_LATENCY = {NUM_SLAVES{4'd1}},
  parameter int                     TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       reset_n,
  aq32_bus_interconnect_if.slave     cpu,
  output logic [NUM_SLAVES-1:0]      s_strobe,
  input  logic [NUM_SLAVES-1:0]      s_wait,
  input  logic [NUM_SLAVES*32-1:0]   s_rddata,
  output logic                       err_valid,
  output logic                       err_cause,
  output logic [31:0]                err_addr,
  input  logic                       err_clr
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_LAT, ST_ERR} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        lat_cnt_reg, lat_cnt_next;
  logic [TO_W-1:0]   to_cnt_reg, to_cnt_next, to_inc;
  logic              err_valid_reg, err_cause_reg;
  logic [31:0]       err_addr_reg;

  logic [NUM_SLAVES-1:0] hit;
  logic [3:0]            lat_tab [NUM_SLAVES];
  logic [31:0]           rd_tab  [NUM_SLAVES];
  logic [SEL_W-1:0]      sel;
  logic                  mapped;
  logic [3:0]            lat_sel;

  logic                  wait_c, error_c, err_set, err_set_cause;
  logic [31:0]           rddata_c;
  logic [NUM_SLAVES-1:0] strobe_c;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
    assign hit[gi]     = (cpu.cpu_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32];
    assign lat_tab[gi] = SLAVE_LATENCY[4*gi +: 4];
    assign rd_tab[gi]  = s_rddata[32*gi +: 32];
  end

  // Scan downwards so the lowest-index hit is the one left standing.
  always_comb begin
    sel    = '0;
    mapped = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel    = SEL_W'(i);
        mapped = 1'b1;
      end
    end
  end

  assign lat_sel = lat_tab[sel];
  assign to_inc  = (to_cnt_reg == {TO_W{1'b1}}) ? to_cnt_reg : to_cnt_reg + 1'b1;

  always_comb begin
    state_next    = state_reg;
    lat_cnt_next  = lat_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    wait_c        = 1'b0;
    error_c       = 1'b0;
    rddata_c      = '0;
    strobe_c      = '0;
    err_set       = 1'b0;
    err_set_cause = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        lat_cnt_next = '0;
        if (!cpu.cpu_strobe) begin
          to_cnt_next = '0;
        end else if (!mapped) begin
          wait_c      = 1'b1;
          state_next  = ST_ERR;
          err_set     = 1'b1;
          to_cnt_next = '0;
        end else begin
          strobe_c[sel] = 1'b1;
          if (lat_sel == 4'd0) begin
            wait_c   = s_wait[sel];
            rddata_c = rd_tab[sel];
            if (!s_wait[sel]) begin
              to_cnt_next = '0;
            end else if ((TIMEOUT != 0) && (to_cnt_reg == TO_MAX)) begin
              state_next    = ST_ERR;
              err_set       = 1'b1;
              err_set_cause = 1'b1;
              to_cnt_next   = '0;
            end else begin
              to_cnt_next = to_inc;
            end
          end else if (cpu.cpu_wren) begin
            to_cnt_next = '0;
          end else begin
            wait_c       = 1'b1;
            lat_cnt_next = 4'd1;
            state_next   = ST_LAT;
            to_cnt_next  = '0;
          end
        end
      end
      ST_LAT: begin
        to_cnt_next = '0;
        // A dropped strobe abandons the access silently.
        if (!cpu.cpu_strobe || !mapped) begin
          state_next   = ST_IDLE;
          lat_cnt_next = '0;
        end else begin
          strobe_c[sel] = 1'b1;
          if (lat_cnt_reg != lat_sel) begin
            wait_c       = 1'b1;
            lat_cnt_next = lat_cnt_reg + 4'd1;
          end else begin
            rddata_c     = rd_tab[sel];
            state_next   = ST_IDLE;
            lat_cnt_next = '0;
          end
        end
      end
      ST_ERR: begin
        error_c      = cpu.cpu_strobe;
        state_next   = ST_IDLE;
        to_cnt_next  = '0;
        lat_cnt_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      lat_cnt_reg <= '0;
      to_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      to_cnt_reg  <= to_cnt_next;
    end
  end

  // A clear coinciding with a new error still lets the new error in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_reg <= 1'b0;
      err_cause_reg <= 1'b0;
      err_addr_reg  <= '0;
    end else if (err_set && (!err_valid_reg || err_clr)) begin
      err_valid_reg <= 1'b1;
      err_cause_reg <= err_set_cause;
      err_addr_reg  <= cpu.cpu_addr;
    end else if (err_clr) begin
      err_valid_reg <= 1'b0;
      err_cause_reg <= 1'b0;
      err_addr_reg  <= '0;
    end
  end

  assign cpu.cpu_wait   = reset_n & wait_c;
  assign cpu.cpu_error  = reset_n & error_c;
  assign cpu.cpu_rddata = reset_n ? rddata_c : 32'd0;
  assign s_strobe       = reset_n ? strobe_c : '0;
  assign err_valid      = err_valid_reg;
  assign err_cause      = err_cause_reg;
  assign err_addr       = err_addr_reg;

endmodule

// File: tb/tb_aq32_bus_interconnect.sv
// Randomized transaction-level bench for aq32_bus_interconnect against a decode/timing model.
// Slave map: 0 L=1 @FFFFF800, 1 L=3 @0000xxxx, 2 handshake @0001xxxx, 3 L=2 @FFFFFxxx (overlaps 0).
module tb_aq32_bus_interconnect;
  localparam int N       = 4;
  localparam int TIMEOUT = 8;
  localparam logic [N*32-1:0] BASE = {32'hFFFF_F000, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_F800};
  localparam logic [N*32-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F800};
  localparam logic [N*4-1:0]  LAT  = {4'd2, 4'd0, 4'd3, 4'd1};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      s_strobe;
  logic [N-1:0]      s_wait;
  logic [N*32-1:0]   s_rddata;
  logic              err_valid, err_cause, err_clr;
  logic [31:0]       err_addr;

  aq32_bus_interconnect_if bus ();

  aq32_bus_interconnect #(
    .NUM_SLAVES(N), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .SLAVE_LATENCY(LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu(bus.slave),
    .s_strobe(s_strobe), .s_wait(s_wait), .s_rddata(s_rddata),
    .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference map, written out from the slave table above.
  logic [31:0] m_base [N] = '{32'hFFFF_F800, 32'h0000_0000, 32'h0001_0000, 32'hFFFF_F000};
  logic [31:0] m_mask [N] = '{32'hFFFF_F800, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000};
  int          m_lat  [N] = '{1, 3, 0, 2};

  bit          m_valid;
  bit          m_cause;
  logic [31:0] m_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] addr);
    for (int i = 0; i < N; i++)
      if ((addr & m_mask[i]) == m_base[i]) return i;
    return -1;
  endfunction

  task automatic do_txn(input logic [31:0] addr, input logic wren, input int k, input bit clr);
    int          sel, exp_waits, waits, cyc;
    bit          exp_err, exp_cause, done;
    logic [31:0] rd [N];
    logic [31:0] exp_rd;
    logic [3:0]  exp_oh, sw;

    sel = decode(addr);
    for (int i = 0; i < N; i++) rd[i] = $urandom;
    s_rddata = {rd[3], rd[2], rd[1], rd[0]};
    exp_oh   = (sel >= 0) ? 4'(1 << sel) : 4'd0;
    exp_err  = 1'b0;
    exp_cause = 1'b0;
    exp_rd   = 32'd0;
    if (sel < 0) begin
      exp_waits = 1; exp_err = 1'b1;
    end else if (m_lat[sel] == 0) begin
      if (k <= TIMEOUT) begin
        exp_waits = k; exp_rd = rd[sel];
      end else begin
        exp_waits = TIMEOUT + 1; exp_err = 1'b1; exp_cause = 1'b1;
      end
    end else if (wren) begin
      exp_waits = 0;
    end else begin
      exp_waits = m_lat[sel]; exp_rd = rd[sel];
    end

    @(posedge clk); #1;
    bus.cpu_addr   = addr;
    bus.cpu_wren   = wren;
    bus.cpu_strobe = 1'b1;
    err_clr        = clr;
    waits = 0;
    done  = 1'b0;
    for (cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        err_clr = 1'b0;
      end
      sw = 4'($urandom);
      sw[2] = (cyc < k);
      s_wait = sw;
      @(negedge clk);
      if (bus.cpu_wait) begin
        waits++;
        check("strobe_wait", 32'(s_strobe), 32'(exp_oh));
      end else begin
        done = 1'b1;
        check("strobe_done", 32'(s_strobe), exp_err ? 32'd0 : 32'(exp_oh));
        check("waits", 32'(waits), 32'(exp_waits));
        check("error", 32'(bus.cpu_error), 32'(exp_err));
        if (!wren || exp_err) check("rddata", bus.cpu_rddata, exp_rd);
      end
    end
    check("completed", 32'(done), 32'd1);
    @(posedge clk); #1;
    bus.cpu_strobe = 1'b0;
    err_clr        = 1'b0;

    if (clr) m_valid = 1'b0;
    if (clr) m_cause = 1'b0;
    if (clr) m_addr  = 32'd0;
    if (exp_err && !m_valid) begin
      m_valid = 1'b1; m_cause = exp_cause; m_addr = addr;
    end
    @(negedge clk);
    check("err_valid", 32'(err_valid), 32'(m_valid));
    check("err_cause", 32'(err_cause), 32'(m_cause));
    check("err_addr", err_addr, m_addr);
    $display("txn addr=%h wr=%0d k=%0d clr=%0d sel=%0d waits=%0d err=%0d", addr, wren, k, clr, sel, waits, exp_err);
  endtask

  initial begin
    logic [31:0] a;
    m_valid = 1'b0; m_cause = 1'b0; m_addr = 32'd0;
    reset_n        = 1'b0;
    err_clr        = 1'b0;
    s_wait         = '1;
    s_rddata       = {4{32'hDEAD_BEEF}};
    bus.cpu_addr   = 32'hFFFF_F804;
    bus.cpu_wren   = 1'b0;
    bus.cpu_strobe = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wait", 32'(bus.cpu_wait), 32'd0);
    check("rst_strobe", 32'(s_strobe), 32'd0);
    check("rst_rddata", bus.cpu_rddata, 32'd0);
    check("rst_error", 32'(bus.cpu_error), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    @(posedge clk); #1;
    bus.cpu_strobe = 1'b0;
    reset_n = 1'b1;

    // Directed cases, then boundaries around the timeout.
    do_txn(32'hFFFF_F804, 1'b0, 0, 1'b0);
    do_txn(32'h0000_0020, 1'b1, 0, 1'b0);
    do_txn(32'h0000_0024, 1'b0, 0, 1'b0);
    do_txn(32'h0001_0000, 1'b0, 4, 1'b0);
    do_txn(32'h1234_5678, 1'b0, 0, 1'b0);
    do_txn(32'h0001_0004, 1'b0, 20, 1'b0);
    do_txn(32'hFFFF_F004, 1'b0, 0, 1'b1);
    do_txn(32'h1234_0ABC, 1'b1, 0, 1'b0);
    do_txn(32'h1234_0DEF, 1'b0, 0, 1'b1);
    do_txn(32'h0001_0008, 1'b1, 8, 1'b0);
    do_txn(32'h0001_000C, 1'b0, 9, 1'b1);

    // Reset in the middle of a latency count.
    @(posedge clk); #1;
    bus.cpu_addr   = 32'h0000_0010;
    bus.cpu_wren   = 1'b0;
    bus.cpu_strobe = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_wait", 32'(bus.cpu_wait), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_wait", 32'(bus.cpu_wait), 32'd0);
    check("midrst_strobe", 32'(s_strobe), 32'd0);
    check("midrst_rddata", bus.cpu_rddata, 32'd0);
    check("midrst_err_valid", 32'(err_valid), 32'd0);
    @(posedge clk); #1;
    bus.cpu_strobe = 1'b0;
    reset_n = 1'b1;
    m_valid = 1'b0; m_cause = 1'b0; m_addr = 32'd0;
    do_txn(32'h0000_0010, 1'b0, 0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'hFFFF_F800 | ($urandom & 32'h0000_07FC);
        1:       a = $urandom & 32'h0000_FFFC;
        2:       a = 32'h0001_0000 | ($urandom & 32'h0000_FFFC);
        3:       a = 32'hFFFF_F000 | ($urandom & 32'h0000_07FC);
        default: a = 32'h1234_0000 | ($urandom & 32'h0000_FFFC);
      endcase
      do_txn(a, 1'($urandom_range(0, 1)), $urandom_range(0, 11), ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
